// File: rtl/mem_host_bridge.sv
// mem_host_bridge: parses big-endian 'W'/'R' byte commands from a host link
// and performs single 16-bit accesses on the mu0 memory override port,
// answering with read data, an ACK byte, or a NAK byte for unknown opcodes.
module mem_host_bridge #(
  parameter int         READ_LATENCY   = 1,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overrideMemControl,
  output logic        overrideMemRnW,
  output logic [15:0] overrideMemAddr,
  output logic [15:0] overrideMemDataIn,
  input  logic [15:0] overrideMemDataOut,
  output logic        timeout_err
);

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;

  // Idle counter saturates at TIMEOUT_CYCLES-1; reaching it with no byte aborts.
  localparam int             TW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TLIMIT = TW'(TIMEOUT_CYCLES - 1);
  // A read holds the port for READ_LATENCY+1 cycles; the counter marks the last one.
  localparam int             LW     = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [LW-1:0]  LLIMIT = LW'(READ_LATENCY);

  typedef enum logic [3:0] {
    IDLE, GET_AH, GET_AL, GET_DH, GET_DL, ACCESS, SEND_H, SEND_L, SEND_ACK, SEND_NAK
  } stateType;

  stateType       state;
  logic           opIsWrite;
  logic [15:0]    addrReg;
  logic [15:0]    dataReg;
  logic [7:0]     rdLow;
  logic [LW-1:0]  accessCnt;
  logic [TW-1:0]  idleCnt;

  logic rxFire;
  logic txFire;

  assign rxFire            = rx_valid && rx_ready;
  assign txFire            = tx_valid && tx_ready;
  assign overrideMemAddr   = addrReg;
  assign overrideMemDataIn = dataReg;

  // Command FSM; every output it drives is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      opIsWrite          <= 1'b0;
      addrReg            <= '0;
      dataReg            <= '0;
      rdLow              <= '0;
      accessCnt          <= '0;
      idleCnt            <= '0;
      rx_ready           <= 1'b1;
      tx_valid           <= 1'b0;
      tx_data            <= '0;
      overrideMemControl <= 1'b0;
      overrideMemRnW     <= 1'b1;
      timeout_err        <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rxFire) begin
            if (rx_data == OP_W || rx_data == OP_R) begin
              opIsWrite <= (rx_data == OP_W);
              idleCnt   <= '0;
              state     <= GET_AH;
            end else begin
              tx_data  <= NAK_BYTE;
              tx_valid <= 1'b1;
              rx_ready <= 1'b0;
              state    <= SEND_NAK;
            end
          end
        end
        GET_AH, GET_AL, GET_DH, GET_DL: begin
          // An arriving byte takes priority over an expiring timeout.
          if (rxFire) begin
            idleCnt <= '0;
            if (state == GET_AH) begin
              addrReg[15:8] <= rx_data;
              state         <= GET_AL;
            end else if (state == GET_DH) begin
              dataReg[15:8] <= rx_data;
              state         <= GET_DL;
            end else begin
              if (state == GET_AL) addrReg[7:0] <= rx_data;
              else                 dataReg[7:0] <= rx_data;
              if (state == GET_AL && opIsWrite) begin
                state <= GET_DH;
              end else begin
                state              <= ACCESS;
                rx_ready           <= 1'b0;
                overrideMemControl <= 1'b1;
                overrideMemRnW     <= !opIsWrite;
                accessCnt          <= '0;
              end
            end
          end else if (idleCnt == TLIMIT) begin
            idleCnt     <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            idleCnt <= idleCnt + 1'b1;
          end
        end
        ACCESS: begin
          if (opIsWrite) begin
            overrideMemControl <= 1'b0;
            overrideMemRnW     <= 1'b1;
            tx_data            <= ACK_BYTE;
            tx_valid           <= 1'b1;
            state              <= SEND_ACK;
          end else if (accessCnt == LLIMIT) begin
            overrideMemControl <= 1'b0;
            tx_data            <= overrideMemDataOut[15:8];
            rdLow              <= overrideMemDataOut[7:0];
            tx_valid           <= 1'b1;
            state              <= SEND_H;
          end else begin
            accessCnt <= accessCnt + 1'b1;
          end
        end
        SEND_H: begin
          if (txFire) begin
            tx_data <= rdLow;
            state   <= SEND_L;
          end
        end
        SEND_L, SEND_ACK, SEND_NAK: begin
          if (txFire) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_host_bridge.sv
// tb_mem_host_bridge: drives randomized host commands into mem_host_bridge,
// emulates the memory behind the override port, and checks responses, access
// counts and timing against a command-level reference memory.
module tb_mem_host_bridge;

  localparam int RL = 1;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        overrideMemControl;
  logic        overrideMemRnW;
  logic [15:0] overrideMemAddr;
  logic [15:0] overrideMemDataIn;
  logic [15:0] memDataOut;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_host_bridge #(
    .READ_LATENCY  (RL),
    .TIMEOUT_CYCLES(TO),
    .ACK_BYTE      (8'h06),
    .NAK_BYTE      (8'h15)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .overrideMemControl(overrideMemControl),
    .overrideMemRnW    (overrideMemRnW),
    .overrideMemAddr   (overrideMemAddr),
    .overrideMemDataIn (overrideMemDataIn),
    .overrideMemDataOut(memDataOut),
    .timeout_err       (timeout_err)
  );

  int checks = 0;
  int failures = 0;

  // Device-side memory (written only by the DUT) and the reference memory
  // (updated from command semantics).
  logic [15:0] devMem [0:65535];
  logic [15:0] refMem [0:65535];

  int          ctlCycles = 0;
  int          wrCount = 0;
  int          toPulses = 0;
  int          txCycles = 0;
  logic [15:0] lastWAddr = 16'h0;
  logic [15:0] lastWData = 16'h0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] devRead(input logic [15:0] a);
    logic [15:0] v;
    v = devMem[a];
    return ((^v) === 1'bx) ? 16'h0000 : v;
  endfunction

  // Memory behind the override port: data valid one cycle after the first
  // asserted read cycle, random garbage otherwise.
  always @(posedge clk) begin
    if (overrideMemControl && !overrideMemRnW) devMem[overrideMemAddr] <= overrideMemDataIn;
    if (overrideMemControl && overrideMemRnW) memDataOut <= devRead(overrideMemAddr);
    else                                      memDataOut <= 16'($urandom);
  end

  // Activity monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrideMemControl) ctlCycles <= ctlCycles + 1;
      if (overrideMemControl && !overrideMemRnW) begin
        wrCount   <= wrCount + 1;
        lastWAddr <= overrideMemAddr;
        lastWData <= overrideMemDataIn;
      end
      if (timeout_err) toPulses <= toPulses + 1;
      if (tx_valid)    txCycles <= txCycles + 1;
    end
  end

  task automatic checkResetOutputs(input string p);
    checkEq({p, "_rxReady"}, 32'(rx_ready), 32'd1);
    checkEq({p, "_txValid"}, 32'(tx_valid), 32'd0);
    checkEq({p, "_txData"}, 32'(tx_data), 32'h00);
    checkEq({p, "_ctl"}, 32'(overrideMemControl), 32'd0);
    checkEq({p, "_rnw"}, 32'(overrideMemRnW), 32'd1);
    checkEq({p, "_addr"}, 32'(overrideMemAddr), 32'h0000);
    checkEq({p, "_dataIn"}, 32'(overrideMemDataIn), 32'h0000);
    checkEq({p, "_toErr"}, 32'(timeout_err), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkEq("rxAccept", 32'(n), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Waits for a response byte, checks its latency (in cycles after the last
  // handshake) and value, optionally stalls, then handshakes it.
  task automatic recvByte(input string tag, input logic [7:0] exp, input int expWait, input int stall);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkEq({tag, "_wait"}, 32'(n), 32'(expWait));
    checkEq({tag, "_data"}, 32'(tx_data), 32'(exp));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkEq({tag, "_stallValid"}, 32'(tx_valid), 32'd1);
      checkEq({tag, "_stallData"}, 32'(tx_data), 32'(exp));
      checkEq({tag, "_stallRxRdy"}, 32'(rx_ready), 32'd0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  // kind: 0 = write, 1 = read, 2 = unknown opcode.
  task automatic doCmd(input int kind, input logic [15:0] addr, input logic [15:0] data,
                       input int stall, input int bigGapIdx);
    int          c0 = ctlCycles;
    int          w0 = wrCount;
    int          t0 = toPulses;
    int          gaps [5];
    logic [15:0] exp;
    logic [7:0]  op;
    for (int i = 0; i < 5; i++) gaps[i] = $urandom_range(0, 3);
    if (bigGapIdx >= 0) gaps[bigGapIdx] = TO - 1;
    op = 8'h57;
    case (kind)
      0: begin
        sendByte(8'h57, gaps[0]);
        sendByte(addr[15:8], gaps[1]);
        sendByte(addr[7:0], gaps[2]);
        sendByte(data[15:8], gaps[3]);
        sendByte(data[7:0], gaps[4]);
        refMem[addr] = data;
        recvByte("ack", 8'h06, 1, stall);
        checkEq("wrCtlCycles", 32'(ctlCycles - c0), 32'd1);
        checkEq("wrCount", 32'(wrCount - w0), 32'd1);
        checkEq("wrAddr", 32'(lastWAddr), 32'(addr));
        checkEq("wrData", 32'(lastWData), 32'(data));
      end
      1: begin
        op = 8'h52;
        sendByte(8'h52, gaps[0]);
        sendByte(addr[15:8], gaps[1]);
        sendByte(addr[7:0], gaps[2]);
        exp = refMem[addr];
        recvByte("rdH", exp[15:8], RL + 1, stall);
        recvByte("rdL", exp[7:0], 0, 0);
        checkEq("rdCtlCycles", 32'(ctlCycles - c0), 32'(RL + 1));
        checkEq("rdWrCount", 32'(wrCount - w0), 32'd0);
      end
      default: begin
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
        if (bigGapIdx == 99) op = 8'h41;
        sendByte(op, gaps[0]);
        recvByte("nak", 8'h15, 0, stall);
        checkEq("nakCtlCycles", 32'(ctlCycles - c0), 32'd0);
      end
    endcase
    checkEq("cmdToPulses", 32'(toPulses - t0), 32'd0);
    checkEq("cmdTxIdle", 32'(tx_valid), 32'd0);
    checkEq("cmdRxReady", 32'(rx_ready), 32'd1);
    $display("cmd op=%h addr=%h data=%h stall=%0d", op, addr, (kind == 0) ? data : refMem[addr], stall);
  endtask

  initial begin
    int          c0;
    int          t0;
    int          x0;
    int          r;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) refMem[i] = 16'h0000;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: write then read back, unknown opcode.
    doCmd(0, 16'h0010, 16'hBEEF, 0, -1);
    doCmd(1, 16'h0010, 16'h0000, 0, -1);
    doCmd(2, 16'h0000, 16'h0000, 0, 99);

    // Partial command followed by silence must abort once with no response.
    c0 = ctlCycles; t0 = toPulses; x0 = txCycles;
    sendByte(8'h57, 0);
    sendByte(8'h00, 0);
    repeat (TO + 8) @(negedge clk);
    checkEq("toPulse", 32'(toPulses - t0), 32'd1);
    checkEq("toNoTx", 32'(txCycles - x0), 32'd0);
    checkEq("toNoCtl", 32'(ctlCycles - c0), 32'd0);
    checkEq("toRxReady", 32'(rx_ready), 32'd1);
    $display("cmd timeout after W 00");
    doCmd(1, 16'h0000, 16'h0000, 0, -1);

    // Byte arriving on the last allowed cycle still counts.
    doCmd(0, 16'h0102, 16'h1234, 0, 2);
    doCmd(0, 16'h0203, 16'h5678, 0, 4);
    doCmd(1, 16'h0102, 16'h0000, 0, 2);

    // Response stalled by the transmitter.
    doCmd(1, 16'h0010, 16'h0000, 5, -1);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      a = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      doCmd((r < 5) ? 0 : ((r < 9) ? 1 : 2), a, 16'($urandom), $urandom_range(0, 2), -1);
    end

    // Reset in the middle of a write access.
    sendByte(8'h57, 0);
    sendByte(8'h03, 0);
    sendByte(8'h03, 0);
    sendByte(8'hA5, 0);
    sendByte(8'h5A, 0);
    checkEq("rstPreCtl", 32'(overrideMemControl), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midRst");
    @(negedge clk);
    rst_n = 1'b1;
    c0 = ctlCycles; x0 = txCycles;
    repeat (10) @(negedge clk);
    checkEq("rstNoTx", 32'(txCycles - x0), 32'd0);
    checkEq("rstNoCtl", 32'(ctlCycles - c0), 32'd0);
    $display("cmd reset during write access to 0303");
    doCmd(1, 16'h0303, 16'h0000, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1);
  end

endmodule
